fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares the 16-deep, 8-bit circular FIFO between NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- Drives the FIFO's wr/data_in and observes its fifo_full.
- Grants one requester at a time for a bounded burst of up to MAX_BURST beats, so no producer can monopolise the FIFO.
- Never issues a write while the FIFO is full, so the FIFO overflow flag is never set by this block.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_W, 8, data width; must match FIFO data_in.
- MAX_BURST, 4, maximum beats accepted per grant (1..16).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-producer beat valid.
- req_data  in  NUM_REQ*DATA_W  producer i data at bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-producer beat accepted when valid&ready.
- fifo_full  in  1  FIFO full flag (combinational from FIFO pointers).
- fifo_wr  out  1  FIFO write strobe.
- fifo_data  out  DATA_W  FIFO write data.
- grant_active  out  1  a grant is held (state GRANT).
- grant_id  out  IDW  index of granted producer; IDW = max(1, clog2(NUM_REQ)).

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, grant_id=0, grant_active=0, rr_ptr=0, beat_cnt=0. Combinational outputs follow: fifo_wr=0, req_ready=0, fifo_data=0.
- States: IDLE, GRANT.
- IDLE: if any req_valid=1 at a clk edge, the winner is the first set bit searching upward from rr_ptr with wrap-around. That edge registers grant_id=winner, beat_cnt=0, state GRANT. No beat is accepted in IDLE. Latency from first valid to first accepted beat is 1 cycle minimum.
- GRANT, combinational:
  - req_ready[grant_id] = ~fifo_full; all other ready bits = 0.
  - fifo_wr = req_valid[grant_id] & ~fifo_full.
  - fifo_data = req_data of grant_id, or 0 when fifo_wr=0.
- Beat acceptance: a beat is accepted when fifo_wr=1. Each accepted beat increments beat_cnt (width clog2(MAX_BURST+1)).
- Release: at an edge in GRANT, release when either holds:
  - an accepted beat brings beat_cnt to MAX_BURST; or
  - req_valid[grant_id]=0 (producer idle).
- On release: state IDLE, rr_ptr = (grant_id+1) mod NUM_REQ (explicit wrap for non-power-of-2 NUM_REQ), beat_cnt=0. This gives one bubble cycle per grant.
- fifo_full in GRANT: the requester stalls (ready=0, no write), beat_cnt holds, and the grant is retained while valid stays high. There is no timeout.
- Simultaneous FIFO read freeing space: fifo_full is sampled combinationally, so a write is accepted in the same cycle fifo_full drops.
- Fairness: with all producers valid, grants rotate 0,1,2,3,0,…, each for MAX_BURST beats.
- Reset mid-burst: grant is dropped immediately. Beats already accepted are in the FIFO; nothing is partially written.
- Producers must hold req_data stable while valid && !ready. The arbiter does not register data.

Decomposition:
- Shared package fifo_arb_pkg:
  - state enum {IDLE, GRANT};
  - IDW and beat-counter width derivation functions (clog2);
  - default NUM_REQ/DATA_W/MAX_BURST constants.
- One sub-module, fifo_rr_pick: combinational round-robin selector. Inputs: req vector and rr_ptr. Outputs: any_req and winner index.
- Top level holds the FSM, beat counter, rr_ptr and output muxing.

Test Plan:
- Single producer: req_valid=4'b0010 with data 0xA0..0xA5, FIFO empty -> grant_id=1 one cycle later. fifo_wr accepts 0xA0..0xA3 (4 beats), then 1 bubble, then regrant for 0xA4,0xA5. The FIFO reads back 0xA0..0xA5 in order.
- All four valid continuously, FIFO drained every cycle -> grant sequence 0,1,2,3,0, each exactly 4 accepted beats, no other req_ready high during a grant.
- Full stall: write 16 beats so fifo_full=1 -> fifo_wr=0 and req_ready=0 while full; fifo_overflow stays 0. One FIFO read -> the write is accepted in that same cycle.
- Early release: producer 2 drops valid after 2 beats -> return to IDLE, rr_ptr=3. Producer 3 valid is granted next, ahead of producer 0.
- Wrap with NUM_REQ=3: grants rotate 0,1,2,0 with no illegal index 3.
- Reset mid-burst: assert rst_n=0 after beat 2 of a grant -> grant_active=0, fifo_wr=0, req_ready=0 immediately. After release, the first grant goes to the lowest valid index from 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Default sizing matches the 16-deep, 8-bit FIFO it fronts.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

    // Grant index width; a single bit is kept even for a degenerate count.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Beat counter must be able to hold the value MAX_BURST itself.
    function automatic int cnt_width(input int m);
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin selector: first set request at or above rr_ptr,
// wrapping through NUM_REQ-1 back to 0.
module fifo_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic               any_req,
    output logic [IDW-1:0]     winner
);

    logic [NUM_REQ-1:0][IDW-1:0] cand;
    logic [NUM_REQ-1:0]          hit;

    // cand[k] is the index k places after rr_ptr; one extra bit avoids overflow
    // before the explicit wrap, so non-power-of-2 counts never alias.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
        logic [IDW:0] sum;
        assign sum     = {1'b0, rr_ptr} + (IDW+1)'(k);
        assign cand[k] = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ))
                                                    : sum[IDW-1:0];
        assign hit[k]  = req[cand[k]];
    end

    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) winner = cand[k];
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO between NUM_REQ producers,
// granting bounded bursts and never writing into a full FIFO.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ   = DEF_NUM_REQ,
    parameter int  DATA_W    = DEF_DATA_W,
    parameter int  MAX_BURST = DEF_MAX_BURST,
    localparam int IDW       = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_data,
    output logic                      grant_active,
    output logic [IDW-1:0]            grant_id
);

    localparam int              CW         = cnt_width(MAX_BURST);
    localparam logic [CW-1:0]   BURST_LAST = CW'(MAX_BURST);
    localparam logic [IDW-1:0]  ID_LAST    = IDW'(NUM_REQ - 1);

    arb_state_e                     state, state_nxt;
    logic [IDW-1:0]                 grant_nxt;
    logic [IDW-1:0]                 rr_ptr, rr_nxt;
    logic [IDW-1:0]                 winner;
    logic [CW-1:0]                  beat_cnt, beat_nxt, beat_inc;
    logic                           any_req;
    logic                           sel_valid;
    logic                           wr_ok;
    logic [DATA_W-1:0]              sel_data;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data_arr;

    assign req_data_arr = req_data;
    assign sel_valid    = req_valid[grant_id];
    assign sel_data     = req_data_arr[grant_id];
    assign beat_inc     = beat_cnt + CW'(1);

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .any_req (any_req),
        .winner  (winner)
    );

    // fifo_full is used combinationally so a slot freed by a read this
    // cycle is filled in the same cycle.
    always_comb begin
        req_ready = '0;
        wr_ok     = 1'b0;
        fifo_data = '0;
        if (state == GRANT) begin
            req_ready[grant_id] = ~fifo_full;
            wr_ok               = sel_valid & ~fifo_full;
            if (wr_ok) fifo_data = sel_data;
        end
    end

    assign fifo_wr      = wr_ok;
    assign grant_active = (state == GRANT);

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        rr_nxt    = rr_ptr;
        beat_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = GRANT;
                    grant_nxt = winner;
                    beat_nxt  = '0;
                end
            end
            GRANT: begin
                if (wr_ok) beat_nxt = beat_inc;
                // A stalled-but-valid producer keeps the grant; only burst
                // completion or the producer going idle releases it.
                if ((wr_ok && beat_inc == BURST_LAST) || !sel_valid) begin
                    state_nxt = IDLE;
                    rr_nxt    = (grant_id == ID_LAST) ? '0 : grant_id + IDW'(1);
                    beat_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= beat_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: queued producers, a 16-deep FIFO
// model, and a second NUM_REQ=3 instance for the wrap case.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr;
    logic [DATA_W-1:0]         fifo_data;
    logic                      grant_active;
    logic [1:0]                grant_id;

    logic [2:0]  v3_valid;
    logic [23:0] v3_data;
    logic [2:0]  v3_ready;
    logic        full3;
    logic        wr3;
    logic [7:0]  data3;
    logic        ga3;
    logic [1:0]  gid3;

    int total = 0;
    int bad   = 0;

    // producer queues and expected write stream {id, data}
    logic [7:0] pmem [NUM_REQ][32];
    int         head [NUM_REQ];
    int         tail [NUM_REQ];
    logic [9:0] exp_q[$];

    // FIFO model
    logic       fifo_rst_n;
    logic       fifo_rd;
    logic       fifo_overflow;
    logic [7:0] fmem [16];
    int         fcnt, fwp, frp;

    assign fifo_full = (fcnt == 16);

    always @(posedge clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            fcnt <= 0; fwp <= 0; frp <= 0; fifo_overflow <= 1'b0;
        end else begin
            if (fifo_wr && fcnt == 16) fifo_overflow <= 1'b1;
            if (fifo_wr && fcnt < 16) begin
                fmem[fwp] <= fifo_data;
                fwp       <= (fwp + 1) % 16;
            end
            if (fifo_rd && fcnt > 0) frp <= (frp + 1) % 16;
            fcnt <= fcnt + ((fifo_wr && fcnt < 16) ? 1 : 0) - ((fifo_rd && fcnt > 0) ? 1 : 0);
        end
    end

    fifo_wr_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr      (fifo_wr),
        .fifo_data    (fifo_data),
        .grant_active (grant_active),
        .grant_id     (grant_id)
    );

    fifo_wr_arbiter #(.NUM_REQ(3)) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (v3_valid),
        .req_data     (v3_data),
        .req_ready    (v3_ready),
        .fifo_full    (full3),
        .fifo_wr      (wr3),
        .fifo_data    (data3),
        .grant_active (ga3),
        .grant_id     (gid3)
    );

    task automatic drive_prod();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = (head[i] < tail[i]);
            req_data[i*DATA_W +: DATA_W] = (head[i] < tail[i]) ? pmem[i][head[i]] : 8'h00;
        end
    endtask

    task automatic clear_prod();
        for (int i = 0; i < NUM_REQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        drive_prod();
    endtask

    task automatic load(input int p, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            pmem[p][tail[p]] = base + 8'(k);
            exp_q.push_back({2'(p), base + 8'(k)});
            tail[p]++;
        end
        drive_prod();
    endtask

    // One clock: scoreboard the beat offered this cycle, then advance producers.
    task automatic tick();
        logic [NUM_REQ-1:0] acc;
        logic [9:0]         e;
        @(negedge clk);
        acc = req_valid & req_ready;
        if (rst_n && fifo_wr) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got write id=%0d data=%h, required no write", grant_id, fifo_data);
            end else begin
                e = exp_q.pop_front();
                if ({grant_id, fifo_data} !== e) begin
                    bad++;
                    $display("FAIL sb_beat: got id=%0d data=%h, required id=%0d data=%h",
                             grant_id, fifo_data, e[9:8], e[7:0]);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (acc[i]) head[i]++;
        drive_prod();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; fifo_rst_n = 1'b0; fifo_rd = 1'b0; v3_valid = '0;
        clear_prod();
        exp_q.delete();
        tick(); tick();
        rst_n = 1'b1; fifo_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fifo_rst_n = 1'b0; fifo_rd = 1'b0;
        v3_valid = 3'b111; v3_data = 24'h727170; full3 = 1'b0;
        clear_prod();
        load(1, 2, 8'h55);
        exp_q.delete();
        tick(); tick();
        total++;
        if (grant_active !== 1'b0 || grant_id !== 2'd0) begin
            bad++; $display("FAIL reset_grant: got active=%b id=%0d, required 0/0", grant_active, grant_id);
        end
        total++;
        if (fifo_wr !== 1'b0 || fifo_data !== 8'h00) begin
            bad++; $display("FAIL reset_wr: got wr=%b data=%h, required 0/00", fifo_wr, fifo_data);
        end
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_ready: got %b, required 0000", req_ready);
        end
        total++;
        if (ga3 !== 1'b0 || wr3 !== 1'b0 || v3_ready !== 3'b000) begin
            bad++; $display("FAIL reset_dut3: got active=%b wr=%b ready=%b, required 0/0/000", ga3, wr3, v3_ready);
        end
        v3_valid = '0;
        clear_prod();
        rst_n = 1'b1; fifo_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [8:0] exp_ga;
        exp_ga = 9'b011101111;
        apply_reset();
        load(1, 6, 8'hA0);
        for (int i = 0; i < 9; i++) begin
            tick();
            total++;
            if (grant_active !== exp_ga[i] || (grant_active && grant_id !== 2'd1)) begin
                bad++;
                $display("FAIL single_grant cyc%0d: got active=%b id=%0d, required active=%b id=1",
                         i + 1, grant_active, grant_id, exp_ga[i]);
            end
        end
        tick(); tick();
        total++;
        if (exp_q.size() != 0 || fcnt != 6) begin
            bad++; $display("FAIL single_count: got left=%0d fifo=%0d, required 0/6", exp_q.size(), fcnt);
        end
        fifo_rd = 1'b1;
        for (int k = 0; k < 6; k++) begin
            total++;
            if (fmem[frp] !== 8'hA0 + 8'(k)) begin
                bad++; $display("FAIL single_readback %0d: got %h, required %h", k, fmem[frp], 8'hA0 + 8'(k));
            end
            tick();
        end
        fifo_rd = 1'b0;
    endtask

    task automatic test_round_robin();
        int         seq[8];
        int         ns;
        int         rr_exp[5];
        logic       prev;
        logic [3:0] oh;
        rr_exp = '{0, 1, 2, 3, 0};
        ns = 0; prev = 1'b0;
        apply_reset();
        fifo_rd = 1'b1;
        load(0, 4, 8'h00); load(1, 4, 8'h10); load(2, 4, 8'h20); load(3, 4, 8'h30); load(0, 4, 8'h04);
        for (int c = 0; c < 35; c++) begin
            tick();
            if (grant_active && !prev) begin
                if (ns < 8) seq[ns] = int'(grant_id);
                ns++;
            end
            prev = grant_active;
            oh = grant_active ? (4'b0001 << grant_id) : 4'b0000;
            total++;
            if ((req_ready & ~oh) !== 4'b0000) begin
                bad++; $display("FAIL rr_ready cyc%0d: got ready=%b id=%0d, required only granted bit", c, req_ready, grant_id);
            end
        end
        total++;
        if (ns != 5) begin
            bad++; $display("FAIL rr_grants: got %0d grants, required 5", ns);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (seq[i] != rr_exp[i]) begin
                bad++; $display("FAIL rr_order %0d: got %0d, required %0d", i, seq[i], rr_exp[i]);
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL rr_left: got %0d beats pending, required 0", exp_q.size());
        end
        fifo_rd = 1'b0;
    endtask

    task automatic test_full_stall();
        int guard;
        guard = 0;
        apply_reset();
        load(0, 17, 8'hC0);
        while (!fifo_full && guard < 60) begin
            tick();
            guard++;
        end
        total++;
        if (fifo_full !== 1'b1) begin
            bad++; $display("FAIL full_reach: got full=%b after %0d cycles, required 1", fifo_full, guard);
        end
        tick(); tick();
        for (int r = 0; r < 2; r++) begin
            total++;
            if (fifo_wr !== 1'b0 || req_ready !== 4'b0000 || grant_active !== 1'b1) begin
                bad++; $display("FAIL full_stall %0d: got wr=%b ready=%b active=%b, required 0/0000/1",
                                r, fifo_wr, req_ready, grant_active);
            end
            tick();
        end
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        total++;
        if (fifo_full !== 1'b0 || fifo_wr !== 1'b1 || req_ready !== 4'b0001 || fifo_data !== 8'hD0) begin
            bad++; $display("FAIL full_release: got full=%b wr=%b ready=%b data=%h, required 0/1/0001/d0",
                            fifo_full, fifo_wr, req_ready, fifo_data);
        end
        tick(); tick(); tick();
        total++;
        if (fifo_overflow !== 1'b0 || fcnt != 16 || exp_q.size() != 0) begin
            bad++; $display("FAIL full_end: got ovf=%b fifo=%0d left=%0d, required 0/16/0",
                            fifo_overflow, fcnt, exp_q.size());
        end
    endtask

    task automatic test_early_release();
        int   seq[8];
        int   ns;
        logic prev;
        ns = 0;
        apply_reset();
        load(2, 2, 8'h20);
        tick();
        total++;
        if (grant_active !== 1'b1 || grant_id !== 2'd2) begin
            bad++; $display("FAIL early_first: got active=%b id=%0d, required 1/2", grant_active, grant_id);
        end
        load(3, 4, 8'h30); load(0, 4, 8'h00);
        prev = grant_active;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (grant_active && !prev) begin
                if (ns < 8) seq[ns] = int'(grant_id);
                ns++;
            end
            prev = grant_active;
        end
        total++;
        if (ns != 2 || seq[0] != 3 || seq[1] != 0) begin
            bad++; $display("FAIL early_order: got n=%0d first=%0d second=%0d, required 2/3/0", ns, seq[0], seq[1]);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL early_left: got %0d beats pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        int guard;
        guard = 0;
        apply_reset();
        load(1, 1, 8'h10);
        repeat (4) tick();
        load(2, 2, 8'h20); load(1, 4, 8'h18); load(2, 4, 8'h22);
        while (head[2] < 2 && guard < 20) begin
            tick();
            guard++;
        end
        total++;
        if (head[2] != 2) begin
            bad++; $display("FAIL midrst_beats: got %0d beats from producer 2, required 2", head[2]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (grant_active !== 1'b0 || fifo_wr !== 1'b0 || req_ready !== 4'b0000) begin
            bad++; $display("FAIL midrst_drop: got active=%b wr=%b ready=%b, required 0/0/0000",
                            grant_active, fifo_wr, req_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (grant_active !== 1'b1 || grant_id !== 2'd1) begin
            bad++; $display("FAIL midrst_regrant: got active=%b id=%0d, required 1/1", grant_active, grant_id);
        end
        repeat (25) tick();
        total++;
        if (exp_q.size() != 0 || fcnt != 11) begin
            bad++; $display("FAIL midrst_end: got left=%0d fifo=%0d, required 0/11", exp_q.size(), fcnt);
        end
    endtask

    task automatic test_wrap3();
        int   seq[8];
        int   ns;
        int   beats;
        int   rr_exp[4];
        logic prev;
        rr_exp = '{0, 1, 2, 0};
        ns = 0; beats = 0; prev = 1'b0;
        apply_reset();
        v3_data  = 24'h727170;
        v3_valid = 3'b111;
        for (int c = 0; c < 32; c++) begin
            tick();
            if (ga3 && !prev) begin
                if (ns < 8) seq[ns] = int'(gid3);
                ns++;
                beats = 0;
            end
            if (!ga3 && prev) begin
                total++;
                if (beats != 4) begin
                    bad++; $display("FAIL wrap_beats grant%0d: got %0d beats, required 4", ns, beats);
                end
            end
            if (ga3) begin
                total++;
                if (gid3 > 2'd2) begin
                    bad++; $display("FAIL wrap_id: got id=%0d, required <3", gid3);
                end
                if (wr3) begin
                    beats++;
                    total++;
                    if (data3 !== 8'h70 + 8'(gid3)) begin
                        bad++; $display("FAIL wrap_data: got %h, required %h", data3, 8'h70 + 8'(gid3));
                    end
                end
            end
            prev = ga3;
        end
        total++;
        if (ns < 4) begin
            bad++; $display("FAIL wrap_grants: got %0d grants, required at least 4", ns);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (seq[i] != rr_exp[i]) begin
                bad++; $display("FAIL wrap_order %0d: got %0d, required %0d", i, seq[i], rr_exp[i]);
            end
        end
        v3_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_early_release();
        test_reset_mid_burst();
        test_wrap3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
